// File: rtl/flash_read_arbiter_pkg.sv
// Shared port indices, FSM encoding and helpers for the two-port flash read arbiter.
package flash_arb_pkg;

  localparam int PORT_CPU   = 0;
  localparam int PORT_AUDIO = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic [1:0] port_onehot(input logic p);
    logic [1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/flash_arb_rr_select.sv
// Round-robin winner selection for two ports; kept separate so the policy can be swapped.
module flash_arb_rr_select
  import flash_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |req_valid;
    winner = 1'(PORT_CPU);
    if (&req_valid)                winner = ~last_grant;
    else if (req_valid[PORT_AUDIO]) winner = 1'(PORT_AUDIO);
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one QSPI flash read controller between CPU and audio ports, one read in flight.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [2*ADDR_BITS-1:0] req_address,
  output logic [1:0]             req_ready,
  output logic [DATA_BITS-1:0]   rsp_data,
  output logic [1:0]             rsp_valid,
  output logic                   ctrl_valid,
  output logic [ADDR_BITS-1:0]   ctrl_address,
  input  logic                   ctrl_ready,
  input  logic [DATA_BITS-1:0]   ctrl_data,
  input  logic                   ctrl_data_valid
);

  state_e                 state_q;
  logic                   grant_q, last_grant_q;
  logic                   ctrl_valid_q;
  logic [ADDR_BITS-1:0]   ctrl_address_q;
  logic [DATA_BITS-1:0]   rsp_data_q;
  logic [1:0]             rsp_valid_q;
  logic                   winner, any;
  logic                   accept;
  logic [ADDR_BITS-1:0]   win_address;

  flash_arb_rr_select u_sel (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any        (any)
  );

  // Acceptance is combinational so req_ready lands in the same cycle the request is seen.
  assign accept      = (state_q == ST_IDLE) && any;
  assign req_ready   = accept ? port_onehot(winner) : 2'b00;
  assign win_address = winner ? req_address[2*ADDR_BITS-1:ADDR_BITS]
                              : req_address[ADDR_BITS-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b0;
      ctrl_valid_q   <= 1'b0;
      ctrl_address_q <= '0;
      rsp_data_q     <= '0;
      rsp_valid_q    <= 2'b00;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        ST_IDLE: if (accept) begin
          ctrl_address_q <= win_address;
          grant_q        <= winner;
          last_grant_q   <= winner;
          ctrl_valid_q   <= 1'b1;
          state_q        <= ST_ISSUE;
        end
        ST_ISSUE: if (ctrl_ready) begin
          ctrl_valid_q <= 1'b0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: if (ctrl_data_valid) begin
          rsp_data_q  <= ctrl_data;
          rsp_valid_q <= port_onehot(grant_q);
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data outside WAIT has no owner; it is dropped, but a simulation should hear about it.
  always_ff @(posedge clk) begin
    if (!reset && ctrl_data_valid)
      assert (state_q == ST_WAIT)
        else $warning("stray ctrl_data_valid outside WAIT ignored");
  end

  assign ctrl_valid   = ctrl_valid_q;
  assign ctrl_address = ctrl_address_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_valid    = rsp_valid_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: single read, contention, stalls, reset and stray data.
module tb_flash_read_arbiter;

  localparam int AB = 24;
  localparam int DB = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [2*AB-1:0] req_address;
  logic [1:0]      req_ready;
  logic [DB-1:0]   rsp_data;
  logic [1:0]      rsp_valid;
  logic            ctrl_valid;
  logic [AB-1:0]   ctrl_address;
  logic            ctrl_ready;
  logic [DB-1:0]   ctrl_data;
  logic            ctrl_data_valid;

  int checks = 0;
  int errors = 0;

  flash_read_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_address     (req_address),
    .req_ready       (req_ready),
    .rsp_data        (rsp_data),
    .rsp_valid       (rsp_valid),
    .ctrl_valid      (ctrl_valid),
    .ctrl_address    (ctrl_address),
    .ctrl_ready      (ctrl_ready),
    .ctrl_data       (ctrl_data),
    .ctrl_data_valid (ctrl_data_valid)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are then changed 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; req_address = '0;
    ctrl_ready = 1'b0; ctrl_data = '0; ctrl_data_valid = 1'b0;
    cyc(); cyc();
    settle();
    chk("rst_req_ready",  32'(req_ready),    32'h0);
    chk("rst_rsp_valid",  32'(rsp_valid),    32'h0);
    chk("rst_ctrl_valid", 32'(ctrl_valid),   32'h0);
    chk("rst_ctrl_addr",  32'(ctrl_address), 32'h0);
    chk("rst_rsp_data",   rsp_data,          32'h0);
    reset = 1'b0;
    cyc();

    // Single CPU read: ready cycle 3, data cycle 7, response cycle 8.
    req_valid = 2'b01; req_address[AB-1:0] = 24'h100000; settle();
    chk("t1_req_ready_c0", 32'(req_ready), 32'h1);
    cyc(); req_valid = 2'b00; settle();
    chk("t1_ctrl_valid_c1", 32'(ctrl_valid), 32'h1);
    chk("t1_ctrl_addr_c1", 32'(ctrl_address), 32'h100000);
    chk("t1_req_ready_c1", 32'(req_ready), 32'h0);
    cyc(); settle();
    chk("t1_ctrl_valid_c2", 32'(ctrl_valid), 32'h1);
    cyc(); ctrl_ready = 1'b1; settle();
    chk("t1_ctrl_valid_c3", 32'(ctrl_valid), 32'h1);
    cyc(); ctrl_ready = 1'b0; settle();
    chk("t1_ctrl_valid_c4", 32'(ctrl_valid), 32'h0);
    cyc(); cyc(); cyc();
    ctrl_data_valid = 1'b1; ctrl_data = 32'hDEADBEEF; settle();
    chk("t1_rsp_valid_c7", 32'(rsp_valid), 32'h0);
    cyc(); ctrl_data_valid = 1'b0; ctrl_data = '0; settle();
    chk("t1_rsp_valid_c8", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data_c8", rsp_data, 32'hDEADBEEF);
    cyc(); settle();
    chk("t1_rsp_valid_c9", 32'(rsp_valid), 32'h0);
    chk("t1_rsp_data_hold", rsp_data, 32'hDEADBEEF);

    // Contention: last grant was 0, so order is 1,0,1,0,1,0 with minimum turnaround.
    req_valid = 2'b11; req_address = {24'h002000, 24'h001000};
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  exp_oh;
      logic [23:0] exp_addr;
      exp_oh   = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 0) ? 24'h002000 : 24'h001000;
      settle();
      chk($sformatf("rr%0d_req_ready", i), 32'(req_ready), 32'(exp_oh));
      cyc(); ctrl_ready = 1'b1; settle();
      chk($sformatf("rr%0d_ctrl_valid", i), 32'(ctrl_valid), 32'h1);
      chk($sformatf("rr%0d_ctrl_addr", i), 32'(ctrl_address), 32'(exp_addr));
      chk($sformatf("rr%0d_busy_ready", i), 32'(req_ready), 32'h0);
      cyc(); ctrl_ready = 1'b0; ctrl_data_valid = 1'b1; ctrl_data = 32'hA0000000 + i; settle();
      chk($sformatf("rr%0d_wait_valid", i), 32'(ctrl_valid), 32'h0);
      cyc(); ctrl_data_valid = 1'b0; settle();
      chk($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'(exp_oh));
      chk($sformatf("rr%0d_rsp_data", i), rsp_data, 32'hA0000000 + i);
    end
    req_valid = 2'b00; settle();
    chk("rr_end_req_ready", 32'(req_ready), 32'h0);
    cyc();

    // Port 0 raised while a port 1 read sits in WAIT.
    req_valid = 2'b10; req_address = {24'h003000, 24'h004000}; settle();
    chk("w_req_ready_p1", 32'(req_ready), 32'h2);
    cyc(); req_valid = 2'b00; ctrl_ready = 1'b1; settle();
    chk("w_ctrl_addr", 32'(ctrl_address), 32'h3000);
    cyc(); ctrl_ready = 1'b0; req_valid = 2'b01; settle();
    chk("w_no_ready_0", 32'(req_ready), 32'h0);
    cyc(); ctrl_data_valid = 1'b1; ctrl_data = 32'h12345678; settle();
    chk("w_no_ready_1", 32'(req_ready), 32'h0);
    cyc(); ctrl_data_valid = 1'b0; settle();
    chk("w_rsp_valid_p1", 32'(rsp_valid), 32'h2);
    chk("w_rsp_data", rsp_data, 32'h12345678);
    chk("w_req_ready_p0", 32'(req_ready), 32'h1);

    // Stalled ctrl_ready with port 1 pending: command held, nothing accepted.
    cyc(); req_valid = 2'b10;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk($sformatf("st%0d_ctrl_valid", i), 32'(ctrl_valid), 32'h1);
      chk($sformatf("st%0d_ctrl_addr", i), 32'(ctrl_address), 32'h4000);
      chk($sformatf("st%0d_req_ready", i), 32'(req_ready), 32'h0);
      cyc();
    end
    ctrl_ready = 1'b1;
    cyc(); ctrl_ready = 1'b0; settle();
    chk("st_wait_valid", 32'(ctrl_valid), 32'h0);

    // Reset while in WAIT, then late data: no response, reset values everywhere.
    reset = 1'b1; req_valid = 2'b00;
    cyc(); reset = 1'b0; ctrl_data_valid = 1'b1; ctrl_data = 32'h55555555; settle();
    chk("rw_ctrl_valid", 32'(ctrl_valid), 32'h0);
    chk("rw_ctrl_addr", 32'(ctrl_address), 32'h0);
    chk("rw_rsp_data0", rsp_data, 32'h0);
    chk("rw_req_ready", 32'(req_ready), 32'h0);
    cyc(); ctrl_data_valid = 1'b0; settle();
    chk("rw_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rw_rsp_data1", rsp_data, 32'h0);
    req_valid = 2'b11; req_address = {24'h002000, 24'h001000}; settle();
    chk("rw_prio_port1", 32'(req_ready), 32'h2);
    cyc(); req_valid = 2'b00; ctrl_ready = 1'b1; settle();
    chk("rw_ctrl_addr2", 32'(ctrl_address), 32'h2000);
    cyc(); ctrl_ready = 1'b0; ctrl_data_valid = 1'b1; ctrl_data = 32'hCAFEF00D;
    cyc(); ctrl_data_valid = 1'b0; settle();
    chk("rw_rsp_valid2", 32'(rsp_valid), 32'h2);
    chk("rw_rsp_data2", rsp_data, 32'hCAFEF00D);

    // Stray data in IDLE is dropped.
    cyc(); ctrl_data_valid = 1'b1; ctrl_data = 32'h11111111;
    cyc(); ctrl_data_valid = 1'b0; settle();
    chk("sd_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("sd_rsp_data", rsp_data, 32'hCAFEF00D);
    chk("sd_ctrl_valid", 32'(ctrl_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
